// File: rtl/b1_trk_pkg.sv
// Shared constants for the B1 tracking channel: code geometry, NCO defaults,
// Gold-code generator polynomials and the PRN to G2 phase-select table.
package b1_trk_pkg;

   localparam int          CODE_LEN  = 2046;
   localparam int          NCO_W     = 32;
   localparam logic [NCO_W-1:0] FCW_INIT = 32'h10E5_6041;
   localparam logic [10:0] CHIP_LAST = 11'(CODE_LEN - 1);

   // bit0 = stage 1; the generator output is stage 11
   localparam logic [10:0] G1_INIT = 11'b010_1010_1010;
   localparam logic [10:0] G2_INIT = 11'b010_1010_1010;

   // feedback taps: G1 = 1+x+x7+x8+x9+x10+x11, G2 = 1+x+x2+x3+x4+x5+x8+x9+x11
   localparam logic [10:0] G1_POLY = 11'b111_1100_0001;
   localparam logic [10:0] G2_POLY = 11'b101_1001_1111;

   // PRN n lives at index n-1; each entry selects two G2 stages
   localparam logic [10:0] PRN_G2_TAPS [0:9] = '{
      11'h005, 11'h009, 11'h011, 11'h021, 11'h081,
      11'h101, 11'h201, 11'h401, 11'h042, 11'h00C
   };

endpackage

// File: rtl/b1_gold_lfsr.sv
// G1/G2 Gold-code pair. Steps once per chip, reloads the INIT words at the
// truncated epoch boundary, and phase-selects G2 through the tap mask.
module b1_gold_lfsr
   import b1_trk_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        step_i,
   input  logic        reload_i,
   input  logic [10:0] taps_i,
   output logic        chip_o
);

   logic [10:0] g1_q, g1_d;
   logic [10:0] g2_q, g2_d;

   // Reload beats step so a restart landing on a chip edge starts clean.
   always_comb begin
      g1_d = g1_q;
      g2_d = g2_q;
      if (reload_i) begin
         g1_d = G1_INIT;
         g2_d = G2_INIT;
      end else if (step_i) begin
         g1_d = {g1_q[9:0], ^(g1_q & G1_POLY)};
         g2_d = {g2_q[9:0], ^(g2_q & G2_POLY)};
      end else begin
         g1_d = g1_q;
         g2_d = g2_q;
      end
   end

   // Generator state registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         g1_q <= G1_INIT;
         g2_q <= G2_INIT;
      end else begin
         g1_q <= g1_d;
         g2_q <= g2_d;
      end
   end

   assign chip_o = g1_q[10] ^ (^(g2_q & taps_i));

endmodule

// File: rtl/b1_code_nco.sv
// B1 BOC(1,1) local replica: code NCO, half/chip counters, E/P/L symbol line,
// epoch pulse, and the FCW latch that only follows the loop filter at epochs.
module b1_code_nco
   import b1_trk_pkg::*;
(
   input  logic              rx_clk,
   input  logic              rx_rst_n,
   input  logic [NCO_W-1:0]  rx_prn_fcw,
   input  logic [10:0]       rx_g2_taps,
   input  logic              rx_code_load,
   output logic              tx_loc_bocE,
   output logic              tx_loc_bocP,
   output logic              tx_loc_bocL,
   output logic              tx_prn_sop,
   output logic [10:0]       tx_chip_cnt
);

   logic [NCO_W-1:0] acc_q, acc_d;
   logic [NCO_W-1:0] fcw_q, fcw_d;
   logic             half_q, half_d;
   logic [10:0]      chip_q, chip_d;
   logic [2:0]       sr_q, sr_d;
   logic [2:0]       flag_q, flag_d;
   logic             sop_q, sop_d;

   logic [NCO_W:0]   sum_s;
   logic             hc_tick_s;
   logic             wrap_s;
   logic             step_s;
   logic             reload_s;
   logic             chip_s;

   assign sum_s     = {1'b0, acc_q} + {1'b0, fcw_q};
   assign hc_tick_s = sum_s[NCO_W];
   assign wrap_s    = (chip_q == CHIP_LAST);
   assign step_s    = hc_tick_s & half_q & ~rx_code_load;
   assign reload_s  = rx_code_load | (step_s & wrap_s);

   b1_gold_lfsr u_lfsr (
      .clk_i    (rx_clk),
      .rst_n_i  (rx_rst_n),
      .step_i   (step_s),
      .reload_i (reload_s),
      .taps_i   (rx_g2_taps),
      .chip_o   (chip_s)
   );

   // Next state: a load restarts everything; a tick advances half/chip and the symbol line.
   always_comb begin
      acc_d  = sum_s[NCO_W-1:0];
      fcw_d  = fcw_q;
      half_d = half_q;
      chip_d = chip_q;
      sr_d   = sr_q;
      flag_d = flag_q;
      sop_d  = 1'b0;
      if (rx_code_load) begin
         acc_d  = '0;
         fcw_d  = rx_prn_fcw;
         half_d = 1'b0;
         chip_d = 11'd0;
         sr_d   = 3'b000;
         flag_d = 3'b000;
      end else if (hc_tick_s) begin
         half_d = ~half_q;
         sr_d   = {sr_q[1:0], chip_s ^ half_q};
         flag_d = {flag_q[1:0], (chip_q == 11'd0) && !half_q};
         sop_d  = flag_q[0];
         if (half_q && wrap_s) begin
            chip_d = 11'd0;
            fcw_d  = rx_prn_fcw;
         end else if (half_q) begin
            chip_d = chip_q + 11'd1;
         end else begin
            chip_d = chip_q;
         end
      end else begin
         sop_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge rx_clk) begin
      if (!rx_rst_n) begin
         acc_q  <= '0;
         fcw_q  <= FCW_INIT;
         half_q <= 1'b0;
         chip_q <= 11'd0;
         sr_q   <= 3'b000;
         flag_q <= 3'b000;
         sop_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         fcw_q  <= fcw_d;
         half_q <= half_d;
         chip_q <= chip_d;
         sr_q   <= sr_d;
         flag_q <= flag_d;
         sop_q  <= sop_d;
      end
   end

   assign tx_loc_bocE = sr_q[0];
   assign tx_loc_bocP = sr_q[1];
   assign tx_loc_bocL = sr_q[2];
   assign tx_prn_sop  = sop_q;
   assign tx_chip_cnt = chip_q;

endmodule

// File: tb/tb_b1_code_nco.sv
// Bench for b1_code_nco: a tick-count reference model feeds a per-cycle
// scoreboard, and each scenario task adds its own timing checks.
module tb_b1_code_nco;
   import b1_trk_pkg::*;

   localparam int EPOCH_HC = 2 * CODE_LEN;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fcw_in;
   logic [10:0] taps;
   logic        code_load;
   logic        bocE, bocP, bocL, sop;
   logic [10:0] chip_cnt;

   always #5 clk = ~clk;

   b1_code_nco dut (
      .rx_clk       (clk),
      .rx_rst_n     (rst_n),
      .rx_prn_fcw   (fcw_in),
      .rx_g2_taps   (taps),
      .rx_code_load (code_load),
      .tx_loc_bocE  (bocE),
      .tx_loc_bocP  (bocP),
      .tx_loc_bocL  (bocL),
      .tx_prn_sop   (sop),
      .tx_chip_cnt  (chip_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // golden code tables, one entry per chip of the truncated epoch
   logic        g1_out [0:CODE_LEN-1];
   logic [10:0] g2_st  [0:CODE_LEN-1];

   // reference model state
   logic [31:0] m_acc;
   logic [31:0] m_fcw;
   int          m_k;
   logic        m_tick;
   logic        m_e, m_p, m_l, m_sop;

   typedef struct packed {
      logic        e;
      logic        p;
      logic        l;
      logic        sop;
      logic [10:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_cur;

   task automatic build_code();
      logic [11:1] s1, s2;
      logic        f1, f2;
      s1 = G1_INIT;
      s2 = G2_INIT;
      for (int c = 0; c < CODE_LEN; c++) begin
         g1_out[c] = s1[11];
         g2_st[c]  = s2;
         f1 = s1[1] ^ s1[7] ^ s1[8] ^ s1[9] ^ s1[10] ^ s1[11];
         f2 = s2[1] ^ s2[2] ^ s2[3] ^ s2[4] ^ s2[5] ^ s2[8] ^ s2[9] ^ s2[11];
         s1 = {s1[10:1], f1};
         s2 = {s2[10:1], f2};
      end
   endtask

   // BOC symbol for half-chip j counted from the start of the code
   function automatic logic sym(int j);
      int c;
      c = (j / 2) % CODE_LEN;
      return g1_out[c] ^ (^(g2_st[c] & taps)) ^ j[0];
   endfunction

   // One clock: advance the model with the inputs the DUT samples, queue the expectation.
   task automatic clock_cycle();
      logic [32:0] s;
      @(posedge clk);
      m_tick = 1'b0;
      if (!rst_n) begin
         m_acc = 32'd0; m_fcw = FCW_INIT; m_k = 0;
         m_e = 1'b0; m_p = 1'b0; m_l = 1'b0; m_sop = 1'b0;
      end else if (code_load) begin
         m_acc = 32'd0; m_fcw = fcw_in; m_k = 0;
         m_e = 1'b0; m_p = 1'b0; m_l = 1'b0; m_sop = 1'b0;
      end else begin
         s     = {1'b0, m_acc} + {1'b0, m_fcw};
         m_acc = s[31:0];
         m_sop = 1'b0;
         if (s[32]) begin
            m_tick = 1'b1;
            m_k++;
            m_e   = sym(m_k - 1);
            m_p   = (m_k >= 2) ? sym(m_k - 2) : 1'b0;
            m_l   = (m_k >= 3) ? sym(m_k - 3) : 1'b0;
            m_sop = (m_k >= 2) && (((m_k - 2) % EPOCH_HC) == 0);
            if ((m_k % EPOCH_HC) == 0) m_fcw = fcw_in;
         end
      end
      exp_q.push_back({m_e, m_p, m_l, m_sop, 11'((m_k % EPOCH_HC) / 2)});
      cyc++;
      #1;
   endtask

   // Scoreboard: pop the expectation for the last edge and compare every output.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_cur = exp_q.pop_front();
         n_tests++;
         if ({bocE, bocP, bocL, sop, chip_cnt} !== exp_cur) begin
            n_fail++;
            $display("FAIL scoreboard cyc=%0d got E%b P%b L%b sop%b cnt%0d exp E%b P%b L%b sop%b cnt%0d",
                     cyc, bocE, bocP, bocL, sop, chip_cnt,
                     exp_cur.e, exp_cur.p, exp_cur.l, exp_cur.sop, exp_cur.cnt);
         end
      end
   end

   task automatic pulse_load(input logic [31:0] f);
      fcw_in    = f;
      code_load = 1'b1;
      clock_cycle();
      code_load = 1'b0;
   endtask

   task automatic test_reset();
      int first;
      rst_n = 1'b0;
      repeat (3) clock_cycle();
      n_tests++;
      if ({bocE, bocP, bocL, sop, chip_cnt} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got %h exp 0", {bocE, bocP, bocL, sop, chip_cnt});
      end
      rst_n = 1'b1;
      first = -1;
      for (int i = 1; i <= 40; i++) begin
         clock_cycle();
         if (sop && first < 0) first = i;
      end
      // two ticks at FCW_INIT need 31 cycles from a zero accumulator
      n_tests++;
      if (first != 31) begin
         n_fail++;
         $display("FAIL reset_first_sop got %0d exp 31", first);
      end
   endtask

   int load_cyc;

   task automatic test_basic();
      int sop_t[2];
      int sop_n;
      sop_t[0] = -1; sop_t[1] = -1; sop_n = 0;
      taps = PRN_G2_TAPS[0];
      pulse_load(32'h8000_0000);
      load_cyc = cyc;
      for (int i = 0; i < 8200 && sop_n < 2; i++) begin
         clock_cycle();
         if (sop) begin
            if (sop_n < 2) sop_t[sop_n] = cyc - load_cyc;
            sop_n++;
         end
         if (m_tick && m_k == EPOCH_HC) begin
            n_tests++;
            if (dut.u_lfsr.g1_q !== G1_INIT || dut.u_lfsr.g2_q !== G2_INIT || chip_cnt !== 11'd0) begin
               n_fail++;
               $display("FAIL wrap_reload got g1=%h g2=%h cnt=%0d exp g1=%h g2=%h cnt=0",
                        dut.u_lfsr.g1_q, dut.u_lfsr.g2_q, chip_cnt, G1_INIT, G2_INIT);
            end
         end
         if (m_tick && m_k == EPOCH_HC + 1) begin
            n_tests++;
            if ({bocE, bocP, bocL} !== {sym(EPOCH_HC), sym(EPOCH_HC - 1), sym(EPOCH_HC - 2)}) begin
               n_fail++;
               $display("FAIL wrap_epl got %b exp %b", {bocE, bocP, bocL},
                        {sym(EPOCH_HC), sym(EPOCH_HC - 1), sym(EPOCH_HC - 2)});
            end
         end
      end
      n_tests++;
      if (sop_t[0] != 4) begin
         n_fail++;
         $display("FAIL basic_first_sop got %0d exp 4", sop_t[0]);
      end
      n_tests++;
      if (sop_t[1] - sop_t[0] != 8184) begin
         n_fail++;
         $display("FAIL basic_epoch_period got %0d exp 8184", sop_t[1] - sop_t[0]);
      end
   endtask

   task automatic test_fcw_change();
      int sop_t[2];
      int sop_n;
      sop_t[0] = -1; sop_t[1] = -1; sop_n = 0;
      for (int i = 0; i < 5000 && m_k != EPOCH_HC + 2000; i++) clock_cycle();
      n_tests++;
      if (chip_cnt !== 11'd1000) begin
         n_fail++;
         $display("FAIL change_at_chip got %0d exp 1000", chip_cnt);
      end
      fcw_in = 32'h4000_0000;
      repeat (1000) clock_cycle();
      // the running epoch keeps one tick per two cycles
      n_tests++;
      if (chip_cnt !== 11'd1250) begin
         n_fail++;
         $display("FAIL change_same_epoch got %0d exp 1250", chip_cnt);
      end
      for (int i = 0; i < 21000 && sop_n < 2; i++) begin
         clock_cycle();
         if (sop) begin
            if (sop_n < 2) sop_t[sop_n] = cyc - load_cyc;
            sop_n++;
         end
      end
      n_tests++;
      if (sop_t[0] != 16376) begin
         n_fail++;
         $display("FAIL change_sop3 got %0d exp 16376", sop_t[0]);
      end
      n_tests++;
      if (sop_t[1] - sop_t[0] != 16368) begin
         n_fail++;
         $display("FAIL change_slow_period got %0d exp 16368", sop_t[1] - sop_t[0]);
      end
   endtask

   task automatic test_code_load();
      int n_sop, at;
      n_sop = 0; at = -1;
      taps = PRN_G2_TAPS[2];
      pulse_load(32'h8000_0000);
      for (int i = 0; i < 7000 && m_k != 3001; i++) clock_cycle();
      clock_cycle();
      // next edge carries a tick at chip 1500 half 1; the load lands on it
      pulse_load(32'h8000_0000);
      n_tests++;
      if (chip_cnt !== 11'd0) begin
         n_fail++;
         $display("FAIL load_on_tick_cnt got %0d exp 0", chip_cnt);
      end
      for (int i = 1; i <= 8; i++) begin
         clock_cycle();
         if (sop) begin
            n_sop++;
            at = i;
         end
      end
      n_tests++;
      if (n_sop != 1 || at != 4) begin
         n_fail++;
         $display("FAIL load_sop got count=%0d at=%0d exp count=1 at=4", n_sop, at);
      end
   endtask

   task automatic test_fcw_zero();
      int bad, at;
      bad = 0; at = -1;
      pulse_load(32'h0000_0000);
      for (int i = 0; i < 300; i++) begin
         clock_cycle();
         if ({bocE, bocP, bocL, sop, chip_cnt} !== 15'd0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL fcw_zero_frozen got %0d nonzero cycles exp 0", bad);
      end
      pulse_load(32'h8000_0000);
      for (int i = 1; i <= 6; i++) begin
         clock_cycle();
         if (sop && at < 0) at = i;
      end
      n_tests++;
      if (at != 4) begin
         n_fail++;
         $display("FAIL fcw_zero_restart_sop got %0d exp 4", at);
      end
   endtask

   task automatic test_reset_mid();
      longint unsigned ticks;
      repeat (1000) clock_cycle();
      rst_n = 1'b0;
      clock_cycle();
      rst_n = 1'b1;
      n_tests++;
      if ({bocE, bocP, bocL, sop, chip_cnt} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got %h exp 0", {bocE, bocP, bocL, sop, chip_cnt});
      end
      repeat (3000) clock_cycle();
      ticks = (longint'(3000) * longint'(FCW_INIT)) >> 32;
      n_tests++;
      if (chip_cnt !== 11'(ticks / 2)) begin
         n_fail++;
         $display("FAIL reset_mid_fcw_init got %0d exp %0d", chip_cnt, ticks / 2);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      code_load = 1'b0;
      fcw_in    = 32'h8000_0000;
      taps      = 11'h005;
      m_acc = 32'd0; m_fcw = FCW_INIT; m_k = 0; m_tick = 1'b0;
      m_e = 1'b0; m_p = 1'b0; m_l = 1'b0; m_sop = 1'b0;
      build_code();
      test_reset();
      test_basic();
      test_fcw_change();
      test_code_load();
      test_fcw_zero();
      test_reset_mid();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/b1_code_nco.md
# b1_code_nco

Local BOC replica generator for the B1 tracking channel. A 32-bit code NCO steps a G1/G2 Gold-code generator and a half-chip subcarrier. It produces the early/prompt/late inversion flags and the code-epoch pulse that the downstream correlator/discriminator stage consumes as `rx_loc_bocE/P/L` and `rx_prn_sop`. The code rate comes from the loop filter's `tx_prn_fcw`, closing the DLL.

## Interface
- `CODE_LEN`, 2046: chips per code epoch.
- `NCO_W`, 32: phase accumulator width.
- `FCW_INIT`, 32'h10E5_6041: FCW used after reset. This is a 4.092 MHz half-chip rate at fs = 62 MHz.
- `G1_INIT`, 11'b01010101010: G1 load value, bit0 = stage 1.
- `G2_INIT`, 11'b01010101010: G2 load value.
- `rx_clk`, in, 1: sample clock; single clock domain.
- `rx_rst_n`, in, 1: reset, synchronous, active-low.
- `rx_prn_fcw`, in, 32: code FCW from the loop filter. One accumulator carry equals one half-chip.
- `rx_g2_taps`, in, 11: G2 phase-select mask (bit k = stage k+1). Sampled continuously.
- `rx_code_load`, in, 1: one-cycle pulse that restarts the code at chip 0.
- `tx_loc_bocE`, out, 1: early replica symbol. 1 = invert sample.
- `tx_loc_bocP`, out, 1: prompt replica symbol.
- `tx_loc_bocL`, out, 1: late replica symbol.
- `tx_prn_sop`, out, 1: one-cycle pulse on the first cycle the prompt symbol is chip 0, half 0.
- `tx_chip_cnt`, out, 11: chip index of the generator (early) stage.

## Operation
- `acc[NCO_W-1:0] <= acc + fcw_act` every cycle. The carry out is `hc_tick`, giving at most one tick per cycle. `fcw_act = 0` freezes all state.
- `fcw_act` is loaded from `rx_prn_fcw` only at the edge where the generator enters chip 0, half 0 (epoch boundary), or on `rx_code_load`. The FCW is constant across every integration epoch.
- `half` toggles on each `hc_tick`.
  - On a 1→0 transition both LFSRs step once and `tx_chip_cnt` increments.
  - When `tx_chip_cnt == CODE_LEN-1`, it wraps to 0 and the LFSRs reload `G1_INIT`/`G2_INIT`. The code is truncated, not free-running, so there is no 2047th chip.
- G1 polynomial: 1+x+x7+x8+x9+x10+x11. G2 polynomial: 1+x+x2+x3+x4+x5+x8+x9+x11.
- `chip = G1[stage11] ^ ^(G2 & rx_g2_taps)`.
- `sym = chip ^ half`, which is BOC(1,1) sign as an inversion flag.
- 3-entry symbol shift register, shifted on `hc_tick` with the new `sym` entering at `sr[0]`:
  - E = `sr[0]`, P = `sr[1]`, L = `sr[2]`.
  - E/L spacing is ±½ chip around P.
- A parallel 3-entry flag register carries `first = (chip_cnt==0 && half==0)` for the symbol entering `sr[0]`. `tx_prn_sop <= hc_tick & flag[0]`, registered on the same edge that moves that symbol into `sr[1]`.
- `rx_code_load` restarts the code. Reset has priority over it.
  - `acc`, `half`, `tx_chip_cnt` ← 0; LFSRs ← INIT; `sr` and flags ← 0.
  - `fcw_act` ← `rx_prn_fcw`.
- Reset: the same as `rx_code_load`, except `fcw_act` ← `FCW_INIT`. All outputs read 0.

## Timing
- All outputs are registered. E/P/L change one cycle after the `hc_tick` edge and hold until the next tick.
- First prompt chip-0 symbol appears on the second tick after reset or load. `tx_prn_sop` is high for exactly that cycle.
- Epoch period = `2*CODE_LEN` ticks. At constant fcw this is `2*CODE_LEN*2^NCO_W/fcw` cycles ±1.
- `rx_code_load` coinciding with `hc_tick`: load wins, and no shift or sop occurs that cycle.
- An FCW change mid-epoch takes effect at the next epoch boundary.
- `tx_prn_sop` is never asserted in two consecutive cycles for any fcw < 2^32.

## Structure
- Package `b1_trk_pkg` holds:
  - `CODE_LEN`, `G1_INIT`, `G2_INIT`, `FCW_INIT`;
  - the polynomial tap constants;
  - the PRN→`g2_taps` table (localparam array).
- Sub-module `b1_gold_lfsr`:
  - contains the G1/G2 pair;
  - inputs: step, reload, taps;
  - output: chip.
- The top level owns the NCO, half/chip counters, shift registers and FCW latch.

## Test plan
- Reset release, fcw = 32'h8000_0000, taps = 11'b000_0000_0101 → tick every 2 cycles. Sop is first seen 4 cycles after reset release, then every 8184 cycles. E/P/L match the golden model chip-for-chip over 3 epochs.
- fcw = 0 → all outputs stay 0 and `tx_chip_cnt` stays 0 indefinitely. Then set fcw = 32'h8000_0000 with a `rx_code_load` pulse → normal start.
- Change fcw 32'h8000_0000 → 32'h4000_0000 at chip 1000 → current epoch keeps a tick every 2 cycles. The next epoch ticks every 4 cycles, giving 16368 cycles per epoch.
- `rx_code_load` at chip 1500, coinciding with a tick → `tx_chip_cnt` = 0 next cycle. Sop occurs 2 ticks later, with no spurious sop.
- `rx_rst_n` low for 1 cycle mid-epoch → all outputs are 0 the next cycle, and `fcw_act` = `FCW_INIT`. The epoch period becomes 2*2046*2^32/0x10E5_6041 ≈ 62000 cycles.
- Wrap check: at chip 2045→0, both LFSRs equal INIT. E leads P by exactly one tick and L lags P by one tick.
